i2c_master: RTL
===============

I2C_MASTER -- requirements
Module: i2c_master

Interface
- REQ-001 Parameter CLK_DIV, default 4; number of clk cycles per SCL quarter-period, legal range 1..255.
- REQ-002 Parameter I2C_DATA_WIDTH, default 8; bits per data byte.
- REQ-003 Parameter I2C_ADDR_WIDTH, default 7; slave address bits, excluding the R/W bit.
- REQ-004 Port clk, input, 1; the single clock, rising edge.
- REQ-005 Port rst, input, 1; asynchronous, active-high reset.
- REQ-006 Port cmd_valid, input, 1; transfer request.
- REQ-007 Port cmd_ready, output, 1; high only in IDLE.
- REQ-008 Port cmd_addr, input, I2C_ADDR_WIDTH; slave address.
- REQ-009 Port cmd_rw, input, 1; 1 = read, 0 = write.
- REQ-010 Port cmd_len, input, 8; byte count, where 0 means address phase only.
- REQ-011 Port wr_data, input, I2C_DATA_WIDTH; next write byte.
- REQ-012 Port wr_req, output, 1; one-cycle pulse when wr_data is sampled.
- REQ-013 Port rd_data, output, I2C_DATA_WIDTH; received byte.
- REQ-014 Port rd_valid, output, 1; one-cycle pulse when rd_data is updated.
- REQ-015 Port busy, output, 1; high whenever the state is not IDLE.
- REQ-016 Port done, output, 1; one-cycle pulse on return to IDLE.
- REQ-017 Port nack, output, 1; set on a slave NACK, cleared when the next command is accepted.
- REQ-018 Ports scl_i and sda_i, input, 1 each; synchronized bus levels.
- REQ-019 Ports scl_oe and sda_oe, output, 1 each; 1 pulls the open-drain line low, 0 releases it.

Function
- REQ-020 A command is accepted on the cycle where cmd_valid and cmd_ready are both high; cmd_addr, cmd_rw and cmd_len are latched on that cycle.
- REQ-021 States are IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK and STOP.
- REQ-022 Every bit period is 4 quarters of CLK_DIV clk cycles each.
  - SCL is released in quarters 1 and 2 and pulled low in quarters 0 and 3.
  - SDA changes only in quarter 0.
  - Received bits are sampled at the end of quarter 1.
- REQ-023 START: with SCL released, SDA is pulled low for 2 quarters, then SCL is pulled low.
- REQ-024 ADDR: shift {cmd_addr, cmd_rw} out MSB first, then go to ADDR_ACK.
- REQ-025 ADDR_ACK: release SDA and sample it.
  - 1 (NACK): set nack and go to STOP.
  - 0 (ACK) with cmd_len = 0: go to STOP.
  - 0 (ACK) otherwise: go to WDATA or RDATA according to cmd_rw.
- REQ-026 WDATA:
  - Pulse wr_req in the first cycle of the state and latch wr_data in that same cycle.
  - Shift the byte out MSB first, then go to WACK.
- REQ-027 WACK: on NACK, set nack and go to STOP; on ACK, decrement the remaining count, then go to WDATA if the count is nonzero, else to STOP.
- REQ-028 RDATA: shift in I2C_DATA_WIDTH bits MSB first, update rd_data, pulse rd_valid, then go to RACK.
- REQ-029 RACK: drive ACK (pull SDA low) if bytes remain after this one; drive NACK (release SDA) on the last byte. Then go to RDATA or STOP.
- REQ-030 STOP: pull SDA low while SCL is low, release SCL, then release SDA 2 quarters later; go to IDLE and pulse done.
- REQ-031 cmd_valid is ignored while busy; no command queueing.
- REQ-032 End-to-end latency for a transfer of N bytes is (2 + 9*(N+1)) * 4 * CLK_DIV clk cycles, with no stretching.

Reset
- REQ-033 While rst is high, the state is IDLE; scl_oe = 0, sda_oe = 0, busy = 0, done = 0, nack = 0, wr_req = 0, rd_valid = 0, rd_data = 0, cmd_ready = 1, and all counters are 0.
- REQ-034 Reset asserted mid-transfer releases both lines immediately; no STOP is generated.

Configuration
- REQ-035 The macro I2C_MASTER_CLK_STRETCH_EN controls clock-stretching support.
  - Defined: the quarter counter holds in quarter 1 while scl_oe = 0 and scl_i = 0, so a slave can stretch the clock.
  - Undefined: scl_i is ignored and timing is strictly counter-based.

Verification
- REQ-036 Write: addr 0x50, rw 0, len 2, data 0xA5 then 0x3C, slave ACKs every byte -> SDA carries 0xA0, 0xA5, 0x3C; 2 wr_req pulses; done pulses; nack = 0.
- REQ-037 Read: addr 0x50, rw 1, len 2, slave returns 0x12 then 0x34 -> rd_valid pulses with 0x12 then 0x34; master ACKs byte 1 and NACKs byte 2; STOP follows.
- REQ-038 Address NACK: addr 0x7F, no slave present -> nack = 1, STOP is generated, no wr_req pulse, done pulses.
- REQ-039 Reset mid-byte: assert rst during bit 3 of ADDR -> scl_oe = 0 and sda_oe = 0 within the same cycle; the block is in IDLE with cmd_ready = 1 after rst deasserts.
- REQ-040 Stretch (with I2C_MASTER_CLK_STRETCH_EN defined): slave holds SCL low for 50 cycles at ADDR bit 0 -> the bit period grows by 50 cycles and the data is correct.
- REQ-041 cmd_len = 0: addr 0x20 -> START, address byte, ACK, STOP; done pulses and there are no data phases.

Source files
------------

// File: rtl/i2c_master.sv
// i2c_master: single-master I2C byte-transfer engine; define I2C_MASTER_CLK_STRETCH_EN to let slaves stretch SCL.
module i2c_master #(
  parameter int CLK_DIV = 4,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int I2C_ADDR_WIDTH = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [I2C_ADDR_WIDTH-1:0] cmd_addr,
  input  logic                      cmd_rw,
  input  logic [7:0]                cmd_len,
  input  logic [I2C_DATA_WIDTH-1:0] wr_data,
  output logic                      wr_req,
  output logic [I2C_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      nack,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_oe,
  output logic                      sda_oe
);
  localparam int AW1 = I2C_ADDR_WIDTH + 1;
  localparam int SW = AW1 > I2C_DATA_WIDTH ? AW1 : I2C_DATA_WIDTH;
  typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP} state_t;
  state_t state, nstate;
  logic [7:0] div, bitcnt, rem;
  logic [1:0] q;
  logic [SW-1:0] sreg;
  logic rw, hold, qend, bend, samp, accept, first, last_bit, bitclk, shifting;
`ifdef I2C_MASTER_CLK_STRETCH_EN
  assign hold = q == 2'd1 && !scl_oe && !scl_i;
`else
  assign hold = scl_i & 1'b0;
`endif
  assign qend = div == 8'(CLK_DIV - 1) && !hold;
  assign bend = qend && q == 2'd3;
  assign samp = qend && q == 2'd1;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign first = q == 2'd0 && div == 8'd0 && bitcnt == 8'd0;
  assign last_bit = bitcnt == (state == ADDR ? 8'(I2C_ADDR_WIDTH) : 8'(I2C_DATA_WIDTH - 1));
  assign bitclk = q[1] == q[0];
  assign shifting = state == ADDR || state == WDATA || state == RDATA;
  always_comb begin
    nstate = state;
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    wr_req = 1'b0;
    case (state)
      IDLE: nstate = accept ? START : IDLE;
      START: begin
        sda_oe = q[1];
        nstate = bend ? ADDR : START;
      end
      ADDR: begin
        scl_oe = bitclk;
        sda_oe = !sreg[SW-1];
        nstate = bend && last_bit ? ADDR_ACK : ADDR;
      end
      ADDR_ACK: begin
        scl_oe = bitclk;
        nstate = !bend ? ADDR_ACK : nack || rem == 8'd0 ? STOP : rw ? RDATA : WDATA;
      end
      WDATA: begin
        scl_oe = bitclk;
        wr_req = first;
        // sreg only holds the new byte after this first cycle
        sda_oe = first ? !wr_data[I2C_DATA_WIDTH-1] : !sreg[SW-1];
        nstate = bend && last_bit ? WACK : WDATA;
      end
      WACK: begin
        scl_oe = bitclk;
        nstate = !bend ? WACK : nack || rem == 8'd1 ? STOP : WDATA;
      end
      RDATA: begin
        scl_oe = bitclk;
        nstate = bend && last_bit ? RACK : RDATA;
      end
      RACK: begin
        scl_oe = bitclk;
        sda_oe = rem != 8'd1;
        nstate = !bend ? RACK : rem == 8'd1 ? STOP : RDATA;
      end
      STOP: begin
        scl_oe = q == 2'd0;
        sda_oe = q != 2'd3;
        nstate = bend ? IDLE : STOP;
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      div <= 8'd0;
      q <= 2'd0;
      bitcnt <= 8'd0;
      rem <= 8'd0;
      sreg <= '0;
      rw <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      nack <= 1'b0;
    end else begin
      state <= nstate;
      rd_valid <= 1'b0;
      done <= state == STOP && bend;
      div <= state == IDLE || qend ? 8'd0 : hold ? div : div + 8'd1;
      q <= state == IDLE ? 2'd0 : qend ? q + 2'd1 : q;
      if (accept) begin
        rw <= cmd_rw;
        rem <= cmd_len;
        nack <= 1'b0;
        sreg <= SW'({cmd_addr, cmd_rw}) << (SW - AW1);
      end
      if (shifting && bend) bitcnt <= last_bit ? 8'd0 : bitcnt + 8'd1;
      if ((state == ADDR || state == WDATA) && bend) sreg <= sreg << 1;
      if (state == WDATA && first) sreg <= SW'(wr_data) << (SW - I2C_DATA_WIDTH);
      if (state == RDATA && samp) begin
        sreg <= {sreg[SW-2:0], sda_i};
        if (last_bit) begin
          rd_data <= {sreg[I2C_DATA_WIDTH-2:0], sda_i};
          rd_valid <= 1'b1;
        end
      end
      if ((state == ADDR_ACK || state == WACK) && samp && sda_i) nack <= 1'b1;
      if ((state == WACK || state == RACK) && bend) rem <= rem - 8'd1;
    end
  end
endmodule
